pixel_pack_writer: RTL

Parametrised successor to the two-pixel SRAM writer. It packs `PIX_PER_WORD` incoming pixels of `PIX_W` bits into one SRAM word and queues the words in a small FIFO. Queued words are written through the single-port SRAM controller handshake. It frames capture on VSYNC and ends the frame either on a JPEG EOI marker (FF D9) or on VSYNC. The block sits between the pixel capture front end and the SRAM controller; its `frame_end`/`stop_addr` hand off to the readout/send process.

---
 rtl/pixel_pack_writer_if.sv | 13 +
 rtl/pixel_pack_writer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pixel_pack_writer_if.sv
// pixel_pack_writer_if: write-only handshake between the pixel packer and the single-port SRAM controller
interface pixel_pack_writer_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16
);
  logic [ADDR_W-1:0] sram_addr;
  logic [WORD_W-1:0] sram_data;
  logic              sram_rw;
  logic              sram_start_n;
  logic              sram_ready;
  modport master (output sram_addr, sram_data, sram_rw, sram_start_n, input sram_ready);
  modport slave (input sram_addr, sram_data, sram_rw, sram_start_n, output sram_ready);
endinterface

// File: rtl/pixel_pack_writer.sv
// pixel_pack_writer: packs pixels into SRAM words, queues them in a FIFO and writes them through the SRAM handshake
module pixel_pack_writer #(
  parameter int PIX_W = 8,
  parameter int PIX_PER_WORD = 2,
  parameter int WORD_W = PIX_W * PIX_PER_WORD,
  parameter int ADDR_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit VSYNC_ACTIVE = 1'b0,
  parameter bit EOI_DETECT = 1'b1,
  localparam int LW = $clog2(PIX_PER_WORD),
  localparam int LCW = LW > 0 ? LW : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W+LW-1:0] pix_addr,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic                 pix_we,
  input  logic                 pix_vsync,
  input  logic                 rearm,
  pixel_pack_writer_if.master  sram,
  output logic                 capture_en,
  output logic                 frame_end,
  output logic                 error,
  output logic                 overflow,
  output logic [ADDR_W-1:0]    stop_addr,
  output logic [ADDR_W:0]      word_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] S_WAIT_ACT = 3'd0, S_WAIT_INACT = 3'd1, S_CAPTURE = 3'd2, S_FLUSH = 3'd3, S_DONE = 3'd4;
  localparam logic [1:0] W_IDLE = 2'd0, W_STROBE = 2'd1, W_BUSY = 2'd2, W_REL = 2'd3;

  logic [2:0]               fstate;
  logic [1:0]               wstate;
  logic                     we_prev, pix_edge, eoi_ff;
  logic [PIX_W-1:0]         pd_q;
  logic [ADDR_W+LW-1:0]     pa_q;
  logic [LCW-1:0]           lane;
  logic [WORD_W-1:0]        acc, word_next, push_word;
  logic [ADDR_W-1:0]        word_addr, push_addr, addr_q;
  logic [WORD_W-1:0]        data_q;
  logic [ADDR_W+WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]            wp, rp;
  logic [CW-1:0]            count;
  logic vs_act, pix_hit, eoi_hit, vs_hit, take, last, push, push_ok, pop, full, fifo_clr, frame_start;

  assign vs_act      = pix_vsync == VSYNC_ACTIVE;
  assign pix_hit     = fstate == S_CAPTURE && pix_edge;
  assign eoi_hit     = EOI_DETECT && pix_hit && eoi_ff && pd_q == PIX_W'(8'hD9);
  assign vs_hit      = fstate == S_CAPTURE && vs_act && !eoi_hit;
  assign take        = pix_hit && !vs_hit;
  assign last        = lane == LCW'(PIX_PER_WORD - 1);
  assign word_next   = acc | (WORD_W'(pd_q) << (PIX_W * int'(lane)));
  assign push        = (take && (last || eoi_hit)) || (!EOI_DETECT && vs_hit && lane != '0);
  assign push_word   = take ? word_next : acc;
  assign push_addr   = (take && lane == '0) ? ADDR_W'(pa_q >> LW) : word_addr;
  assign fifo_clr    = EOI_DETECT && vs_hit;
  assign frame_start = fstate == S_WAIT_INACT && !vs_act;
  assign full        = count == CW'(FIFO_DEPTH);
  assign pop         = wstate == W_IDLE && count != '0 && sram.sram_ready;
  assign push_ok     = push && (!full || pop);
  assign capture_en  = fstate == S_CAPTURE;

  assign sram.sram_addr    = addr_q;
  assign sram.sram_data    = data_q;
  assign sram.sram_rw      = 1'b0;
  assign sram.sram_start_n = wstate != W_STROBE;

  // Register the pixel strobe edge together with its data and address
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      we_prev  <= 1'b0;
      pix_edge <= 1'b0;
      pd_q     <= '0;
      pa_q     <= '0;
    end else begin
      we_prev  <= pix_we;
      pix_edge <= pix_we && !we_prev;
      pd_q     <= pix_data;
      pa_q     <= pix_addr;
    end

  // Frame sequencing and lane packing
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fstate    <= S_WAIT_ACT;
      lane      <= '0;
      acc       <= '0;
      word_addr <= '0;
      eoi_ff    <= 1'b0;
      frame_end <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (fstate)
        S_WAIT_ACT: if (vs_act) fstate <= S_WAIT_INACT;
        S_WAIT_INACT: if (!vs_act) begin
          fstate    <= S_CAPTURE;
          frame_end <= 1'b0;
          lane      <= '0;
          acc       <= '0;
          eoi_ff    <= 1'b0;
        end
        S_CAPTURE: if (vs_hit) begin
          lane   <= '0;
          acc    <= '0;
          fstate <= EOI_DETECT ? S_WAIT_INACT : S_FLUSH;
          error  <= error || EOI_DETECT;
        end else if (take) begin
          eoi_ff <= pd_q == PIX_W'(8'hFF);
          if (lane == '0) word_addr <= ADDR_W'(pa_q >> LW);
          lane   <= (last || eoi_hit) ? '0 : lane + 1'b1;
          acc    <= (last || eoi_hit) ? '0 : word_next;
          if (eoi_hit) fstate <= S_FLUSH;
        end
        S_FLUSH: if (count == '0 && wstate == W_IDLE) begin
          frame_end <= 1'b1;
          fstate    <= S_DONE;
        end
        S_DONE: if (rearm) begin
          frame_end <= 1'b0;
          fstate    <= S_WAIT_ACT;
        end
        default: fstate <= S_WAIT_ACT;
      endcase
    end

  // Word FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= {push_addr, push_word};

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (fifo_clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count    <= count + CW'(push_ok) - CW'(pop);
      overflow <= overflow || (push && !push_ok);
    end

  // SRAM write handshake: pop, strobe one cycle, wait for the controller busy/ready cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wstate     <= W_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      stop_addr  <= '0;
      word_count <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (pop) begin
          {addr_q, data_q} <= mem[rp];
          wstate           <= W_STROBE;
        end
        W_STROBE: begin
          stop_addr <= addr_q;
          wstate    <= W_BUSY;
        end
        W_BUSY: if (!sram.sram_ready) wstate <= W_REL;
        W_REL: if (sram.sram_ready) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
      word_count <= frame_start ? '0 : (wstate == W_STROBE && !(&word_count)) ? word_count + 1'b1 : word_count;
    end
endmodule
